tdm_capture: RTL and testbench
==============================

# tdm_capture

Receive-side counterpart of the eight-digit time-multiplexed seven-segment driver: it samples the active-low anode lines AN[7:0] and segment lines CA..CG, filters switching glitches, and rebuilds the eight per-digit segment patterns. It sits in display loop-back and self-test paths, fed from the driver's pins or from an external board, and outputs the decoded patterns in the same 7-bit per-digit format the driver consumes.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a pattern is accepted (≥2).
- TIMEOUT_CYCLES, 400000: clocks without any digit write before `stale` asserts.
- CLK100MHZ  input  1  system clock, 100 MHz; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- an  input  8  anode lines, active-low, bit i = digit i.
- seg  input  7  segment lines {CA,CB,CC,CD,CE,CF,CG}, active-low, bit 6 = CA.
- DIG0..DIG7  output  7 each  captured pattern per digit, same bit order and polarity as `seg`.
- frame_done  output  1  one-cycle pulse when a full frame has been captured.
- valid  output  1  sticky: at least one full frame captured since reset.
- stale  output  1  no digit written for TIMEOUT_CYCLES clocks.
- err_multi  output  1  sticky: a stable sample had more than one anode low.

## Operation
- `an` and `seg` pass through a 2-flop synchronizer (pins may be asynchronous).
- Stability filter: synchronized 15-bit word {an,seg} compared with the previous one; any difference clears the stability counter and enters SETTLE.
- States: SETTLE (counting), HOLD (pattern accepted, waiting for change). Reset state SETTLE, counter 0.
- SETTLE: counter increments on each equal sample; when it reaches STABLE_CYCLES-1 the word is evaluated once and state goes to HOLD:
  - exactly one `an` bit low (index i): DIGi <= seg; set seen[i].
  - all `an` high: blank phase, no write.
  - two or more low: no write, err_multi <= 1.
- HOLD: no further evaluation until the word changes (→ SETTLE, counter 0). Re-evaluation of an unchanged word never happens, so a frozen display causes one write only.
- Frame tracking: seen[7:0] mask. On a write to digit 7 with seen[6:0] all set, frame_done pulses, valid <= 1, seen clears (the digit-7 write itself leaves seen = 0). Writes out of order are legal; only completeness matters.
- Stale: counter reset to 0 on every digit write, saturates at TIMEOUT_CYCLES; stale = (counter == TIMEOUT_CYCLES). Clears the cycle after the next write.
- err_multi and valid clear only on reset.

## Timing
- Reset values: DIG0..DIG7 = 7'h7F (all segments off), frame_done 0, valid 0, stale 0, err_multi 0, seen 0, synchronizer flops 8'hFF / 7'h7F.
- Latency: a pin value held constant first sampled at edge k appears on DIGi after edge k+STABLE_CYCLES+2; frame_done/err_multi update on that same edge.
- Any change during SETTLE, including one-cycle glitches, restarts the count; no partial writes.
- Reset assertion mid-frame returns all state immediately (asynchronous); first capture after release requires a full STABLE_CYCLES window.
- stale asserts on the edge where the counter reaches TIMEOUT_CYCLES after the last write.

## Structure
- Package tdm_pkg: N_DIGITS = 8, SEG_W = 7, SEG_BLANK = 7'h7F, state enum {SETTLE, HOLD}.
- Sub-module sync_stable (parameter W, STABLE_CYCLES): 2-flop synchronizer plus stability counter, outputs the synchronized word and a one-cycle `accept` strobe; tdm_capture holds decode, digit registers, seen mask and stale timer.

## Test plan
- Scan an = ~(1<<i), seg = 7'h40+i for i=0..7, each held 100 cycles -> DIGi = 7'h40+i, one frame_done on digit 7, valid = 1.
- Glitch: 3-cycle pulse of seg = 7'h00 inside a 100-cycle hold of 7'h79 on digit 2 -> DIG2 stays 7'h79, no other write.
- an = 8'b1111_0011 held 50 cycles -> err_multi = 1, no DIG changes, frame not completed.
- Scan digits 0..6 then stop with an = 8'hFF; TIMEOUT_CYCLES = 1000 -> stale at 1000 cycles after last write, no frame_done; resume scan -> stale clears, frame_done only after digit 7 write.
- Reset_n low during digit 4 of a scan -> all DIG = 7'h7F, valid/err_multi 0 immediately; first write exactly STABLE_CYCLES+2 edges after first post-reset sample.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and anode helper for the seven-segment capture path.
// Purely declarative; no latency or flow-control behaviour of its own.
package tdm_pkg;

    localparam int N_DIGITS = 8;
    localparam int SEG_W    = 7;
    localparam logic [SEG_W-1:0]    SEG_BLANK = 7'h7F;
    localparam logic [N_DIGITS-1:0] AN_IDLE   = 8'hFF;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    function automatic int unsigned count_low(input logic [N_DIGITS-1:0] an_word);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_word[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/tdm_capture_sync_stable.sv
// Two-flop synchronizer plus stability filter; accept strobes once per settled word.
// Latency: word constant from edge k strobes accept for edge k+STABLE_CYCLES+2; no backpressure.
module sync_stable
    import tdm_pkg::*;
#(
    parameter int              W             = 15,
    parameter int              STABLE_CYCLES = 16,
    parameter logic [W-1:0]    RST_VAL       = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         accept
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  sync1, sync2, prev;
    logic [CW-1:0] cnt, cnt_nxt;
    state_t        state, state_nxt;
    logic          same;

    assign same = (sync2 == prev);
    assign dout = sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            prev  <= RST_VAL;
            state <= SETTLE;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Any change, even a single-cycle glitch, throws away the count so far.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!same) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == CNT_LAST) state_nxt = HOLD;
                    else                 cnt_nxt   = cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        accept = (state == SETTLE) && same && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/tdm_capture.sv
// Rebuilds eight per-digit segment patterns from multiplexed anode/segment pins.
// Latency: STABLE_CYCLES+2 clocks from first stable sample to DIG write; no backpressure.
module tdm_capture
    import tdm_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic                CLK100MHZ,
    input  logic                reset_n,
    input  logic [N_DIGITS-1:0] an,
    input  logic [SEG_W-1:0]    seg,
    output logic [SEG_W-1:0]    DIG0,
    output logic [SEG_W-1:0]    DIG1,
    output logic [SEG_W-1:0]    DIG2,
    output logic [SEG_W-1:0]    DIG3,
    output logic [SEG_W-1:0]    DIG4,
    output logic [SEG_W-1:0]    DIG5,
    output logic [SEG_W-1:0]    DIG6,
    output logic [SEG_W-1:0]    DIG7,
    output logic                frame_done,
    output logic                valid,
    output logic                stale,
    output logic                err_multi
);

    localparam int WW = N_DIGITS + SEG_W;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic [WW-1:0]       word;
    logic                accept;
    logic [N_DIGITS-1:0] word_an;
    logic [SEG_W-1:0]    word_seg;
    logic [3:0]          n_low;
    logic [2:0]          wr_idx;
    logic                wr_en, multi_en, frame_hit;
    logic [SEG_W-1:0]    dig_q [N_DIGITS];
    logic [N_DIGITS-1:0] seen;
    logic [TW-1:0]       tcnt;

    sync_stable #(
        .W             (WW),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RST_VAL       ({AN_IDLE, SEG_BLANK})
    ) u_sync (
        .clk    (CLK100MHZ),
        .rst_n  (reset_n),
        .din    ({an, seg}),
        .dout   (word),
        .accept (accept)
    );

    assign word_an  = word[WW-1:SEG_W];
    assign word_seg = word[SEG_W-1:0];
    assign n_low    = 4'(count_low(word_an));

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!word_an[i]) wr_idx = 3'(i);
        end
    end

    assign wr_en     = accept && (n_low == 4'd1);
    assign multi_en  = accept && (n_low > 4'd1);
    // Frame completes only on the digit-7 write; order of the other digits is irrelevant.
    assign frame_hit = wr_en && (wr_idx == 3'd7) && (&seen[N_DIGITS-2:0]);

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_DIGITS; i++) dig_q[i] <= SEG_BLANK;
            seen       <= '0;
            frame_done <= 1'b0;
            valid      <= 1'b0;
            err_multi  <= 1'b0;
            tcnt       <= '0;
        end else begin
            frame_done <= frame_hit;
            if (wr_en) begin
                dig_q[wr_idx] <= word_seg;
                if (frame_hit) begin
                    seen  <= '0;
                    valid <= 1'b1;
                end else begin
                    seen[wr_idx] <= 1'b1;
                end
            end
            if (multi_en) err_multi <= 1'b1;
            if (wr_en)              tcnt <= '0;
            else if (tcnt != T_MAX) tcnt <= tcnt + TW'(1);
        end
    end

    assign stale = (tcnt == T_MAX);

    assign DIG0 = dig_q[0];
    assign DIG1 = dig_q[1];
    assign DIG2 = dig_q[2];
    assign DIG3 = dig_q[3];
    assign DIG4 = dig_q[4];
    assign DIG5 = dig_q[5];
    assign DIG6 = dig_q[6];
    assign DIG7 = dig_q[7];

endmodule

// File: tb/tb_tdm_capture.sv
// Randomized scoreboard bench for tdm_capture: pin schedules are turned into per-edge
// expected output snapshots by a run-based reference model and checked by a monitor.
module tb_tdm_capture;

    localparam int STABLE = 16;
    localparam int TMO    = 1000;
    localparam logic [14:0] RST_W = 15'h7FFF;

    typedef struct packed {
        logic [55:0] digs;
        logic        fd;
        logic        vl;
        logic        st;
        logic        er;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] an;
    logic [6:0] seg;
    logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       frame_done, valid, stale, err_multi;

    always #5 clk = ~clk;

    tdm_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .an        (an),
        .seg       (seg),
        .DIG0 (d0), .DIG1 (d1), .DIG2 (d2), .DIG3 (d3),
        .DIG4 (d4), .DIG5 (d5), .DIG6 (d6), .DIG7 (d7),
        .frame_done (frame_done),
        .valid      (valid),
        .stale      (stale),
        .err_multi  (err_multi)
    );

    int    checks   = 0;
    int    failures = 0;
    int    mon_cyc  = 0;
    snap_t exp_q[$];
    snap_t pexp[$];
    logic [14:0] sched[$];
    snap_t mon_e, mon_a;

    function automatic snap_t dut_snap();
        snap_t s;
        s.digs = {d7, d6, d5, d4, d3, d2, d1, d0};
        s.fd = frame_done; s.vl = valid; s.st = stale; s.er = err_multi;
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.digs = {8{7'h7F}};
        s.fd = 1'b0; s.vl = 1'b0; s.st = 1'b0; s.er = 1'b0;
        return s;
    endfunction

    task automatic add_run(input logic [7:0] a, input logic [6:0] s, input int len);
        repeat (len) sched.push_back({a, s});
    endtask

    // Reference model: a pin word held for a whole run of at least STABLE+1 samples
    // (first sample at edge k) is evaluated once at edge k+STABLE+2.
    function automatic void model_phase();
        int n, e, k, len, last_w, nlow, idx;
        int ev_at[];
        logic [14:0] ev_w[];
        logic [14:0] w, prevw;
        logic [6:0]  dg [8];
        logic [7:0]  seen;
        logic        vl, er, fd;
        snap_t       s;
        n = sched.size();
        ev_at = new[n + 2];
        ev_w  = new[n + 2];
        prevw = RST_W;
        e = 1;
        while (e <= n) begin
            k = e;
            w = sched[e-1];
            while (e <= n && sched[e-1] == w) e++;
            len = e - k;
            if (w != prevw && len >= STABLE + 1 && k + STABLE + 2 <= n) begin
                ev_at[k + STABLE + 2] = 1;
                ev_w[k + STABLE + 2]  = w;
            end
            prevw = w;
        end
        for (int i = 0; i < 8; i++) dg[i] = 7'h7F;
        seen = '0; vl = 0; er = 0; last_w = 0;
        pexp.delete();
        for (int t = 1; t <= n; t++) begin
            fd = 0;
            if (ev_at[t] == 1) begin
                nlow = $countones(~ev_w[t][14:7]);
                if (nlow == 1) begin
                    idx = 0;
                    for (int i = 0; i < 8; i++) if (!ev_w[t][7+i]) idx = i;
                    dg[idx] = ev_w[t][6:0];
                    last_w = t;
                    if (idx == 7 && seen[6:0] == 7'h7F) begin
                        fd = 1; vl = 1; seen = '0;
                    end else begin
                        seen[idx] = 1'b1;
                    end
                end else if (nlow >= 2) begin
                    er = 1;
                end
            end
            s.digs = {dg[7], dg[6], dg[5], dg[4], dg[3], dg[2], dg[1], dg[0]};
            s.fd = fd; s.vl = vl; s.er = er;
            s.st = ((t - last_w) >= TMO);
            pexp.push_back(s);
        end
    endfunction

    task automatic check_reset(input string name);
        snap_t a;
        a = dut_snap();
        checks++;
        if (a !== reset_snap()) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, a, reset_snap());
        end
    endtask

    // Releases reset, plays the schedule, then resets asynchronously mid-cycle.
    task automatic run_phase(input string name);
        int n;
        model_phase();
        n = sched.size();
        @(negedge clk);
        reset_n = 1'b1;
        {an, seg} = sched[0];
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            exp_q.push_back(pexp[e-1]);
            #1;
            if (e < n) {an, seg} = sched[e];
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset({name, "_async_reset"});
        sched.delete();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = dut_snap();
            mon_cyc++;
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL cycle_%0d: got digs=%h fd=%b valid=%b stale=%b err=%b required digs=%h fd=%b valid=%b stale=%b err=%b",
                         mon_cyc, mon_a.digs, mon_a.fd, mon_a.vl, mon_a.st, mon_a.er,
                         mon_e.digs, mon_e.fd, mon_e.vl, mon_e.st, mon_e.er);
            end
        end
    end

    task automatic rand_word(output logic [7:0] a, output logic [6:0] s);
        int r, x, y;
        r = $urandom_range(0, 99);
        s = 7'($urandom);
        if (r < 60) begin
            a = ~(8'h01 << $urandom_range(0, 7));
        end else if (r < 85) begin
            a = 8'hFF;
        end else begin
            x = $urandom_range(0, 7);
            y = (x + $urandom_range(1, 7)) % 8;
            a = ~((8'h01 << x) | (8'h01 << y)) & 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [6:0] s;
        logic [14:0] prevw;
        int perm[8];
        int tmp, j;

        reset_n = 1'b0;
        an  = 8'h5A;
        seg = 7'h11;
        #12;
        check_reset("initial_reset");

        // In-order scan, then a second scan cut by reset while digit 4 is shown.
        for (int i = 0; i < 8; i++) add_run(~(8'h01 << i), 7'(8'h40 + i), 100);
        for (int i = 0; i < 4; i++) add_run(~(8'h01 << i), 7'(8'h20 + i), 60);
        add_run(8'hEF, 7'h24, 30);
        run_phase("scan");

        // Glitch on digit 2, then a two-anode-low word.
        add_run(8'hFF, 7'h7F, 20);
        add_run(8'hFB, 7'h79, 40);
        add_run(8'hFB, 7'h00, 3);
        add_run(8'hFB, 7'h79, 57);
        add_run(8'b1111_0011, 7'h2A, 50);
        add_run(8'hFF, 7'h7F, 30);
        run_phase("glitch_multi");

        // Partial frame, long blank to reach stale, then a full frame.
        for (int i = 0; i < 7; i++) add_run(~(8'h01 << i), 7'(8'h10 + i), 40);
        add_run(8'hFF, 7'h7F, 1100);
        for (int i = 0; i < 8; i++) add_run(~(8'h01 << i), 7'(8'h30 + i), 40);
        add_run(8'hFF, 7'h7F, 20);
        run_phase("stale");

        // Random runs mixed with shuffled full scans.
        prevw = RST_W;
        for (int r = 0; r < 4; r++) begin
            for (int q = 0; q < 15; q++) begin
                rand_word(a, s);
                while ({a, s} == prevw) rand_word(a, s);
                if ($urandom_range(0, 9) < 3) add_run(a, s, $urandom_range(1, STABLE - 4));
                else                          add_run(a, s, $urandom_range(STABLE + 4, STABLE + 60));
                prevw = {a, s};
            end
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 8; i++) begin
                a = ~(8'h01 << perm[i]);
                s = 7'($urandom);
                if ({a, s} == prevw) s = s ^ 7'h01;
                add_run(a, s, $urandom_range(STABLE + 4, STABLE + 30));
                prevw = {a, s};
            end
        end
        run_phase("random");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending snapshots required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
